fanout_fork_ctrl: RTL and testbench

- Eager-fork controller for one upstream sparse stream that fans out to NUM_OUT downstream consumers.
- Each consumer is enabled and selected by configuration.
- Per-consumer handshakes are independent; the block records which consumers have already taken the current token.
- Upstream is released only once every active consumer has accepted it.
- Sits between a PE/memory-tile output and its routed fanout sinks. Replaces the all-ready AND combine with a buffered-acceptance scheme.

---
 rtl/fanout_fork_ctrl.sv | 76 +++++++
 tb/tb_fanout_fork_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fanout_fork_ctrl.sv
// Eager-fork controller: one upstream stream broadcast to NUM_OUT consumers with per-consumer acceptance tracking.
// Optional FANOUT_PERF_CNT_EN adds tok_cnt (wrapping transfers) and stall_cnt (saturating stall cycles).
module fanout_fork_ctrl #(
    parameter int NUM_OUT    = 6,
    parameter int DATA_W     = 17,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_OUT-1:0]    cfg_en,
    input  logic [NUM_OUT-1:0]    cfg_sel,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic [NUM_OUT-1:0]    active_mask,
    output logic [DROP_CNT_W-1:0] drop_cnt
`ifdef FANOUT_PERF_CNT_EN
    ,
    output logic [31:0]           tok_cnt,
    output logic [15:0]           stall_cnt
`endif
);

    logic [NUM_OUT-1:0] served;
    logic [NUM_OUT-1:0] act;
    logic [NUM_OUT-1:0] served_next;
    logic               xfer;

    // Handshakes: a beat moves on a channel in any cycle where valid and ready are both high;
    // valid never depends on the same channel's ready, and a raised upstream valid holds until taken.
    always_comb begin
        out_data    = in_data;
        out_valid   = (in_valid && !reset) ? (act & ~served) : '0;
        in_ready    = !reset && (&(~act | served | out_ready));
        xfer        = in_valid && in_ready;
        served_next = xfer ? '0 : (served | (out_valid & out_ready));
        active_mask = act;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            served   <= '0;
            act      <= '0;
            drop_cnt <= '0;
        end else begin
            served <= served_next;
            // Config only switches between tokens so no consumer sees half a route change.
            if (served_next == '0) begin
                act <= cfg_en & cfg_sel;
            end
            if (xfer && (act == '0) && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

`ifdef FANOUT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tok_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (xfer) begin
                tok_cnt <= tok_cnt + 32'd1;
            end
            if (in_valid && !in_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Randomised scoreboard bench for fanout_fork_ctrl; a token-level model tracks which consumers still owe the current token.
// A second instance with a 4-bit drop counter exercises drop_cnt saturation; FANOUT_PERF_CNT_EN adds counter checks.
module tb_fanout_fork_ctrl;

    localparam int NUM_OUT = 6;
    localparam int DATA_W  = 17;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_OUT-1:0] cfg_en;
    logic [NUM_OUT-1:0] cfg_sel;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    logic [NUM_OUT-1:0] active_mask;
    logic [15:0]        drop_cnt;

    logic               sat_in_ready;
    logic [DATA_W-1:0]  sat_out_data;
    logic [NUM_OUT-1:0] sat_out_valid;
    logic [NUM_OUT-1:0] sat_active_mask;
    logic [3:0]         sat_drop_cnt;
`ifdef FANOUT_PERF_CNT_EN
    logic [31:0]        tok_cnt;
    logic [15:0]        stall_cnt;
    logic [31:0]        sat_tok_cnt;
    logic [15:0]        sat_stall_cnt;
    int                 tok_n = 0;
    int                 stall_n = 0;
`endif

    // clock/reset block
    always #5 clk = ~clk;

    fanout_fork_ctrl #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .DROP_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .active_mask(active_mask), .drop_cnt(drop_cnt)
`ifdef FANOUT_PERF_CNT_EN
        , .tok_cnt(tok_cnt), .stall_cnt(stall_cnt)
`endif
    );

    fanout_fork_ctrl #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .DROP_CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(sat_in_ready),
        .out_data(sat_out_data), .out_valid(sat_out_valid), .out_ready(out_ready),
        .active_mask(sat_active_mask), .drop_cnt(sat_drop_cnt)
`ifdef FANOUT_PERF_CNT_EN
        , .tok_cnt(sat_tok_cnt), .stall_cnt(sat_stall_cnt)
`endif
    );

    // scoreboard state
    logic [DATA_W-1:0]  exp_q[$];
    logic [NUM_OUT-1:0] owe = '0;
    logic [NUM_OUT-1:0] cur_mask = '0;
    logic [NUM_OUT-1:0] sched[$];
    int                 drop_n = 0;
    int                 checks = 0;
    int                 passed = 0;
    bit                 last_v = 0;
    bit                 last_xf = 0;
    bit                 last_rst = 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    endtask

    function automatic int sat_min(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // monitor: compares every cycle against the token-level model
    always @(negedge clk) begin
        logic               exp_r;
        logic [NUM_OUT-1:0] hs;
        if (reset) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
`ifdef FANOUT_PERF_CNT_EN
            tok_n = 0;
            stall_n = 0;
`endif
        end else if (in_valid) begin
            exp_r = &(~owe | out_ready);
            check("out_valid", out_valid, owe);
            check("in_ready", in_ready, exp_r);
            check("active_mask", active_mask, cur_mask);
            hs = out_valid & out_ready;
            for (int i = 0; i < NUM_OUT; i++) begin
                if (hs[i] && owe[i] && exp_q.size() != 0) begin
                    check($sformatf("data_c%0d", i), out_data, exp_q[0]);
                    owe[i] = 1'b0;
                end
            end
            if (in_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                owe = '0;
            end
`ifdef FANOUT_PERF_CNT_EN
            if (in_ready) tok_n++;
            else stall_n++;
`endif
        end else begin
            check("idle_out_valid", out_valid, 0);
        end
        assert (reset || last_rst || !last_v || in_valid || last_xf)
            else $error("upstream protocol violation: in_valid dropped mid-token");
        last_v = in_valid;
        last_xf = in_valid && in_ready && !reset;
        last_rst = reset;
    end

    // driver tasks
    task automatic present(input logic [DATA_W-1:0] d, input logic [NUM_OUT-1:0] m);
        exp_q.push_back(d);
        owe = m;
        cur_mask = m;
        in_data = d;
        in_valid = 1'b1;
    endtask

    task automatic step(input logic [NUM_OUT-1:0] rdy, output bit xf);
        out_ready = rdy;
        @(negedge clk);
        xf = in_valid && in_ready && !reset;
        if (xf && cur_mask == '0) drop_n++;
        @(posedge clk);
        #1;
        if (xf) in_valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [NUM_OUT-1:0] en, input logic [NUM_OUT-1:0] sel);
        bit xf;
        cfg_en = en;
        cfg_sel = sel;
        step(NUM_OUT'($urandom_range(0, 63)), xf);
    endtask

    // mode 0: random ready, 1: all ready, 2: ready taken from sched
    task automatic send_token(input logic [DATA_W-1:0] d, input logic [NUM_OUT-1:0] m,
                              input int mode, output int cyc);
        bit                 xf = 0;
        logic [NUM_OUT-1:0] rdy;
        present(d, m);
        cyc = 0;
        while (!xf && cyc < 64) begin
            if (mode == 0) rdy = NUM_OUT'($urandom_range(0, 63));
            else if (mode == 1) rdy = '1;
            else rdy = (sched.size() != 0) ? sched.pop_front() : '0;
            step(rdy, xf);
            cyc++;
        end
        check("token_done", {31'd0, xf}, 1);
        if (!xf) begin
            in_valid = 1'b0;
            owe = '0;
            exp_q.delete();
        end
    endtask

    task automatic check_drops();
        check("drop_cnt", drop_cnt, sat_min(drop_n, 65535));
        check("sat_drop_cnt", sat_drop_cnt, sat_min(drop_n, 15));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit xf;
        reset = 1'b1;
        cfg_en = '1;
        cfg_sel = '1;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state: mask still zero in the first cycle, loads at its end
        @(negedge clk);
        check("post_rst_mask", active_mask, 0);
        check("post_rst_in_ready", in_ready, 1);
        check_drops();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mask_loaded", active_mask, 6'h3F);
        @(posedge clk);
        #1;

        // all-ready broadcast, back-to-back
        for (int k = 0; k < 4; k++) begin
            send_token(DATA_W'(32'h00A + k), 6'h3F, 1, cyc);
            check("bcast_cycles", cyc, 1);
        end
        check_drops();

        // staggered acceptance
        set_cfg(6'h3F, 6'h0F);
        sched = '{6'h03, 6'h04, 6'h00, 6'h08};
        send_token(17'h00123, 6'h0F, 2, cyc);
        check("stagger_cycles", cyc, 4);
        send_token(17'h00124, 6'h0F, 1, cyc);
        check("stagger_next_cycles", cyc, 1);

        // masking
        set_cfg(6'h3F, 6'h05);
        for (int k = 0; k < 20; k++) send_token(DATA_W'($urandom), 6'h05, 0, cyc);

        // config change while a token is partially delivered
        set_cfg(6'h3F, 6'h03);
        present(17'h0BEEF, 6'h03);
        step(6'h01, xf);
        cfg_sel = 6'h02;
        step(6'h00, xf);
        check("midcfg_hold", active_mask, 6'h03);
        step(6'h02, xf);
        check("midcfg_xfer", {31'd0, xf}, 1);
        check("midcfg_switch", active_mask, 6'h02);

        // drop path and saturation of the narrow counter
        set_cfg(6'h00, 6'h3F);
        for (int k = 0; k < 3; k++) begin
            send_token(DATA_W'($urandom), 6'h00, 0, cyc);
            check("drop_cycles", cyc, 1);
        end
        check_drops();
        for (int k = 0; k < 15; k++) send_token(DATA_W'($urandom), 6'h00, 0, cyc);
        check_drops();

        // random traffic with occasional reconfiguration
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0) set_cfg(NUM_OUT'($urandom_range(0, 63)), NUM_OUT'($urandom_range(0, 63)));
            else if ($urandom_range(0, 3) == 0) step(NUM_OUT'($urandom_range(0, 63)), xf);
            send_token(DATA_W'($urandom), cfg_en & cfg_sel, 0, cyc);
        end
        check_drops();

        // reset in the middle of a token
        set_cfg(6'h3F, 6'h3F);
        present(17'h1CAFE, 6'h3F);
        step(6'h04, xf);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        owe = '0;
        drop_n = 0;
        @(negedge clk);
        check("rst_mid_mask", active_mask, 0);
        check_drops();
`ifdef FANOUT_PERF_CNT_EN
        check("rst_tok_cnt", tok_cnt, 0);
        check("rst_stall_cnt", stall_cnt, 0);
`endif
        @(posedge clk);
        #1;
        send_token(17'h1CAFE, 6'h3F, 1, cyc);
        check("replay_cycles", cyc, 1);
        for (int k = 0; k < 10; k++) send_token(DATA_W'($urandom), 6'h3F, 0, cyc);

        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
`ifdef FANOUT_PERF_CNT_EN
        check("tok_cnt", tok_cnt, tok_n);
        check("stall_cnt", stall_cnt, sat_min(stall_n, 65535));
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
